// File: rtl/scenario_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scenario_sequencer
// Brief    : Arms on start and waits for a trigger (optionally phase-aligned),
//            then emits a delayed trigger pulse and an optional detonation pulse.
// Revision : 1.0
// ============================================================================
module scenario_sequencer #(
    parameter int CW = 32,
    parameter int PW = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [7:0]    scen_sel,
    input  logic          scen_start,
    input  logic          scen_abort,
    input  logic          input_trigger,
    input  logic          phase_ref,
    input  logic [CW-1:0] trig_delay,
    input  logic [CW-1:0] det_delay,
    input  logic [PW-1:0] pulse_len,
    output logic          output_trigger,
    output logic          detonation_signal,
    output logic [7:0]    scenario_state,
    output logic [CW-1:0] counter_out,
    output logic          busy,
    output logic          error
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WAIT_TRIG  = 4'd1;
    localparam logic [3:0] S_WAIT_PHASE = 4'd2;
    localparam logic [3:0] S_DELAY_TRIG = 4'd3;
    localparam logic [3:0] S_PULSE_TRIG = 4'd4;
    localparam logic [3:0] S_DELAY_DET  = 4'd5;
    localparam logic [3:0] S_PULSE_DET  = 4'd6;
    localparam logic [3:0] S_DONE       = 4'd7;
    localparam logic [3:0] S_ERROR      = 4'd8;

    logic [3:0]    r_state;
    logic [3:0]    w_next_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_next_count;
    logic          w_timed;

    logic          r_is_phase;
    logic          r_is_cal;
    logic [CW-1:0] r_trig_delay;
    logic [CW-1:0] r_det_delay;
    logic [PW-1:0] r_len_m1;
    logic [CW-1:0] w_len_term;

    logic          r_trig_prev;
    logic          r_phase_prev;
    logic          w_trig_rise;
    logic          w_phase_rise;
    logic          w_start_ok;

    logic          w_out_trig;
    logic          w_out_det;
    logic          w_out_busy;
    logic          w_out_err;
    logic [7:0]    w_out_state;
    logic          r_out_trig;
    logic          r_out_det;
    logic          r_out_busy;
    logic          r_out_err;
    logic [7:0]    r_out_state;

    // Pulse terminal count is kept as length-1 so zero and one behave the same.
    generate
        if (CW > PW) begin : g_len_pad
            assign w_len_term = {{(CW-PW){1'b0}}, r_len_m1};
        end else begin : g_len_trunc
            assign w_len_term = r_len_m1[CW-1:0];
        end
    endgenerate

    assign w_trig_rise  = input_trigger & ~r_trig_prev;
    assign w_phase_rise = phase_ref & ~r_phase_prev;
    assign w_start_ok   = (r_state == S_IDLE) & scen_start & ~scen_abort;

    // Edge-detect history resets high so a level already present at arm time is not an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_prev  <= 1'b1;
            r_phase_prev <= 1'b1;
        end else begin
            r_trig_prev  <= input_trigger;
            r_phase_prev <= phase_ref;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_is_phase   <= 1'b0;
            r_is_cal     <= 1'b0;
            r_trig_delay <= '0;
            r_det_delay  <= '0;
            r_len_m1     <= '0;
        end else if (w_start_ok) begin
            r_is_phase   <= scen_sel[0];
            r_is_cal     <= scen_sel[1];
            r_trig_delay <= trig_delay;
            r_det_delay  <= det_delay;
            r_len_m1     <= (pulse_len == '0) ? '0 : pulse_len - PW'(1);
        end
    end

    // State register (outputs are registered from the next-state decode).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_out_trig  <= 1'b0;
            r_out_det   <= 1'b0;
            r_out_busy  <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_state <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_count     <= w_next_count;
            r_out_trig  <= w_out_trig;
            r_out_det   <= w_out_det;
            r_out_busy  <= w_out_busy;
            r_out_err   <= w_out_err;
            r_out_state <= w_out_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (scen_start) begin
                    w_next_state = (scen_sel > 8'd3) ? S_ERROR : S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (w_trig_rise) begin
                    w_next_state = r_is_phase ? S_WAIT_PHASE : S_DELAY_TRIG;
                end
            end
            S_WAIT_PHASE: begin
                if (w_phase_rise) w_next_state = S_DELAY_TRIG;
            end
            S_DELAY_TRIG: begin
                if (r_count == r_trig_delay) w_next_state = S_PULSE_TRIG;
            end
            S_PULSE_TRIG: begin
                if (r_count == w_len_term) w_next_state = S_DELAY_DET;
            end
            S_DELAY_DET: begin
                if (r_count == r_det_delay) w_next_state = S_PULSE_DET;
            end
            S_PULSE_DET: begin
                if (r_count == w_len_term) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERROR: w_next_state = S_ERROR;
            default: w_next_state = S_IDLE;
        endcase
        if (scen_abort) w_next_state = S_IDLE;
    end

    // Counter restarts at 0 on every state change; it never wraps because each
    // timed state leaves exactly at its terminal count.
    always_comb begin
        w_timed      = (r_state == S_DELAY_TRIG) || (r_state == S_PULSE_TRIG) ||
                       (r_state == S_DELAY_DET)  || (r_state == S_PULSE_DET);
        w_next_count = '0;
        if (w_timed && (w_next_state == r_state)) begin
            w_next_count = r_count + CW'(1);
        end
    end

    always_comb begin
        w_out_trig  = (w_next_state == S_PULSE_TRIG);
        w_out_det   = (w_next_state == S_PULSE_DET) && !r_is_cal;
        w_out_busy  = (w_next_state != S_IDLE);
        w_out_err   = (w_next_state == S_ERROR);
        w_out_state = {4'd0, w_next_state};
    end

    assign output_trigger    = r_out_trig;
    assign detonation_signal = r_out_det;
    assign busy              = r_out_busy;
    assign error             = r_out_err;
    assign scenario_state    = r_out_state;
    assign counter_out       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_scenario_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scenario_sequencer
// Brief    : Scoreboard bench: expected per-cycle outputs are queued as stimulus
//            is applied and compared as each clock edge produces them.
// Revision : 1.0
// ============================================================================
module tb_scenario_sequencer;

    localparam int CW = 32;
    localparam int PW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [7:0]    scen_sel;
    logic          scen_start;
    logic          scen_abort;
    logic          input_trigger;
    logic          phase_ref;
    logic [CW-1:0] trig_delay;
    logic [CW-1:0] det_delay;
    logic [PW-1:0] pulse_len;
    logic          output_trigger;
    logic          detonation_signal;
    logic [7:0]    scenario_state;
    logic [CW-1:0] counter_out;
    logic          busy;
    logic          error;

    typedef struct {
        int     st;
        longint cnt;
        bit     trig;
        bit     det;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string test_name = "init";

    scenario_sequencer #(.CW(CW), .PW(PW)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .scen_sel          (scen_sel),
        .scen_start        (scen_start),
        .scen_abort        (scen_abort),
        .input_trigger     (input_trigger),
        .phase_ref         (phase_ref),
        .trig_delay        (trig_delay),
        .det_delay         (det_delay),
        .pulse_len         (pulse_len),
        .output_trigger    (output_trigger),
        .detonation_signal (detonation_signal),
        .scenario_state    (scenario_state),
        .counter_out       (counter_out),
        .busy              (busy),
        .error             (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", test_name, tag, act, exp);
        end
    endtask

    task automatic push_exp(input int st, input longint cnt, input bit trig, input bit det);
        exp_t e;
        e.st   = st;
        e.cnt  = cnt;
        e.trig = trig;
        e.det  = det;
        sb.push_back(e);
    endtask

    task automatic tick_check();
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk("state",   64'(scenario_state),    64'(e.st));
        chk("counter", 64'(counter_out),       64'(e.cnt));
        chk("trig",    64'(output_trigger),    64'(e.trig));
        chk("det",     64'(detonation_signal), 64'(e.det));
        chk("busy",    64'(busy),              64'(e.st != 0));
        chk("error",   64'(error),             64'(e.st == 8));
    endtask

    task automatic drain();
        while (sb.size() > 0) tick_check();
    endtask

    // Expected sequence from the DELAY_TRIG entry edge up to the return to IDLE.
    task automatic push_trace(input int d, input int k, input int l, input bit cal);
        int p;
        p = (l == 0) ? 1 : l;
        for (int i = 0; i <= d; i++) push_exp(3, i, 1'b0, 1'b0);
        for (int i = 0; i < p; i++)  push_exp(4, i, 1'b1, 1'b0);
        for (int i = 0; i <= k; i++) push_exp(5, i, 1'b0, 1'b0);
        for (int i = 0; i < p; i++)  push_exp(6, i, 1'b0, !cal);
        push_exp(7, 0, 1'b0, 1'b0);
        push_exp(0, 0, 1'b0, 1'b0);
    endtask

    // Start request, then scramble the inputs to prove they were latched.
    task automatic start_scn(input int sel, input int d, input int k, input int l);
        scen_sel   = 8'(sel);
        trig_delay = CW'(d);
        det_delay  = CW'(k);
        pulse_len  = PW'(l);
        scen_start = 1'b1;
        push_exp((sel > 3) ? 8 : 1, 0, 1'b0, 1'b0);
        tick_check();
        scen_start = 1'b0;
        scen_sel   = 8'd2;
        trig_delay = '1;
        det_delay  = '1;
        pulse_len  = PW'(7);
    endtask

    task automatic chk_all_zero();
        chk("state", 64'(scenario_state),    64'd0);
        chk("count", 64'(counter_out),       64'd0);
        chk("trig",  64'(output_trigger),    64'd0);
        chk("det",   64'(detonation_signal), 64'd0);
        chk("busy",  64'(busy),              64'd0);
        chk("error", 64'(error),             64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        scen_sel      = 8'd0;
        scen_start    = 1'b0;
        scen_abort    = 1'b0;
        input_trigger = 1'b0;
        phase_ref     = 1'b0;
        trig_delay    = '0;
        det_delay     = '0;
        pulse_len     = '0;
        repeat (3) @(posedge clock);
        #1;
        test_name = "reset";
        chk_all_zero();
        reset_n = 1'b1;
        push_exp(0, 0, 1'b0, 1'b0);
        tick_check();

        test_name = "experiment";
        start_scn(0, 3, 5, 2);
        push_exp(1, 0, 1'b0, 1'b0);
        push_exp(1, 0, 1'b0, 1'b0);
        tick_check();
        tick_check();
        input_trigger = 1'b1;
        push_trace(3, 5, 2, 1'b0);
        tick_check();
        input_trigger = 1'b0;
        drain();

        test_name = "calibration";
        start_scn(2, 3, 5, 2);
        push_exp(1, 0, 1'b0, 1'b0);
        tick_check();
        input_trigger = 1'b1;
        push_trace(3, 5, 2, 1'b1);
        tick_check();
        input_trigger = 1'b0;
        drain();

        test_name = "phase";
        start_scn(1, 2, 1, 3);
        phase_ref = 1'b1;
        push_exp(1, 0, 1'b0, 1'b0);
        tick_check();
        phase_ref = 1'b0;
        push_exp(1, 0, 1'b0, 1'b0);
        tick_check();
        input_trigger = 1'b1;
        push_exp(2, 0, 1'b0, 1'b0);
        tick_check();
        input_trigger = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_exp(2, 0, 1'b0, 1'b0);
            tick_check();
        end
        phase_ref = 1'b1;
        push_trace(2, 1, 3, 1'b0);
        tick_check();
        phase_ref = 1'b0;
        drain();

        test_name = "boundary";
        input_trigger = 1'b1;
        push_exp(0, 0, 1'b0, 1'b0);
        tick_check();
        start_scn(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push_exp(1, 0, 1'b0, 1'b0);
            tick_check();
        end
        input_trigger = 1'b0;
        push_exp(1, 0, 1'b0, 1'b0);
        tick_check();
        input_trigger = 1'b1;
        push_trace(0, 0, 0, 1'b0);
        tick_check();
        input_trigger = 1'b0;
        drain();

        test_name = "abort";
        start_scn(0, 1, 2, 4);
        input_trigger = 1'b1;
        push_exp(3, 0, 1'b0, 1'b0);
        push_exp(3, 1, 1'b0, 1'b0);
        push_exp(4, 0, 1'b1, 1'b0);
        push_exp(4, 1, 1'b1, 1'b0);
        tick_check();
        input_trigger = 1'b0;
        drain();
        scen_abort = 1'b1;
        push_exp(0, 0, 1'b0, 1'b0);
        tick_check();
        scen_abort = 1'b0;
        push_exp(0, 0, 1'b0, 1'b0);
        tick_check();

        test_name = "async_reset";
        start_scn(0, 0, 10, 1);
        input_trigger = 1'b1;
        push_exp(3, 0, 1'b0, 1'b0);
        push_exp(4, 0, 1'b1, 1'b0);
        push_exp(5, 0, 1'b0, 1'b0);
        push_exp(5, 1, 1'b0, 1'b0);
        push_exp(5, 2, 1'b0, 1'b0);
        tick_check();
        input_trigger = 1'b0;
        drain();
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero();
        #1;
        reset_n = 1'b1;
        push_exp(0, 0, 1'b0, 1'b0);
        tick_check();

        test_name = "start_abort";
        scen_sel   = 8'd0;
        scen_start = 1'b1;
        scen_abort = 1'b1;
        push_exp(0, 0, 1'b0, 1'b0);
        tick_check();
        scen_start = 1'b0;
        scen_abort = 1'b0;
        push_exp(0, 0, 1'b0, 1'b0);
        tick_check();

        test_name = "invalid";
        start_scn(9, 1, 1, 1);
        scen_start    = 1'b1;
        input_trigger = 1'b1;
        push_exp(8, 0, 1'b0, 1'b0);
        tick_check();
        scen_start    = 1'b0;
        input_trigger = 1'b0;
        push_exp(8, 0, 1'b0, 1'b0);
        tick_check();
        scen_abort = 1'b1;
        push_exp(0, 0, 1'b0, 1'b0);
        tick_check();
        scen_abort = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scenario_sequencer.md
# scenario_sequencer

Sequences one synchronization scenario on the trigger/detonation outputs of the synchronization block. It arms on `scen_start` and waits for an external input trigger, optionally aligned to a phase reference. It then emits a delayed output-trigger pulse and, for experiment scenarios only, a delayed detonation pulse, and publishes its state and live delay counter. It drives the `output_ports` bus fields (`output_trigger`, `detonation_signal`, `scenario_state`, `counter_out`) that the scenario multiplexer selects between.

## Interface
- `CW`, default 32: width of the delay counter, `trig_delay`, `det_delay` and `counter_out`.
- `PW`, default 16: width of `pulse_len`.

Ports:
- `clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `scen_sel`  in  8  scenario code: 0 EXPERIMENT, 1 EXPERIMENT_PHASE, 2 CALIBRATION, 3 CALIBRATION_PHASE; any other value is invalid.
- `scen_start`  in  1  start request, sampled only in IDLE.
- `scen_abort`  in  1  synchronous abort; highest priority after reset.
- `input_trigger`  in  1  external trigger, already synchronized to `clock`.
- `phase_ref`  in  1  phase reference, already synchronized to `clock`.
- `trig_delay`  in  CW  cycles from trigger acceptance to the output-trigger pulse.
- `det_delay`  in  CW  cycles from the end of the output-trigger pulse to the detonation pulse.
- `pulse_len`  in  PW  pulse length in cycles; 0 is treated as 1.
- `output_trigger`  out  1  output trigger pulse.
- `detonation_signal`  out  1  detonation pulse; never asserted in calibration scenarios.
- `scenario_state`  out  8  current FSM state code.
- `counter_out`  out  CW  live delay/pulse counter.
- `busy`  out  1  high in every state except IDLE.
- `error`  out  1  high while in ERROR.

## Operation
State codes on `scenario_state`:
- IDLE=0, WAIT_TRIG=1, WAIT_PHASE=2, DELAY_TRIG=3, PULSE_TRIG=4, DELAY_DET=5, PULSE_DET=6, DONE=7, ERROR=8.

Transitions:
- **IDLE:** on `scen_start`=1, latch `scen_sel`, `trig_delay`, `det_delay` and `pulse_len`. Go to ERROR if `scen_sel`>3, else to WAIT_TRIG. Later input changes have no effect until the next start.
- **WAIT_TRIG:** a rising edge of `input_trigger` (current 1, previous-cycle registered 0) leads to WAIT_PHASE for the *_PHASE scenarios, else to DELAY_TRIG.
  - The edge-detect register tracks in all states and resets to 1, so a trigger held high at arm time does not fire.
- **WAIT_PHASE:** a rising edge of `phase_ref`, detected the same way, leads to DELAY_TRIG.
- **DELAY_TRIG:** lasts `trig_delay`+1 cycles, then PULSE_TRIG.
- **PULSE_TRIG:** lasts max(`pulse_len`,1) cycles, then DELAY_DET.
- **DELAY_DET:** lasts `det_delay`+1 cycles, then PULSE_DET.
- **PULSE_DET:** lasts max(`pulse_len`,1) cycles, then DONE.
- **DONE:** lasts one cycle, then IDLE.
- **ERROR:** held until `scen_abort`, then IDLE.

Counter rules:
- The counter is cleared to 0 on entry to each timed state and increments by 1 per cycle. The timed state exits when the counter equals its terminal value (delay, or length−1).
- The counter is 0 in IDLE, WAIT_*, DONE and ERROR.
- No wrap: a delay of 2^CW−1 is legal and exits at the terminal count.

Output decoding:
- `output_trigger` = 1 exactly in PULSE_TRIG.
- `detonation_signal` = 1 exactly in PULSE_DET when the latched scenario is 0 or 1; it stays 0 for scenarios 2 and 3, which still traverse PULSE_DET with identical timing.

Priority and boundary cases:
- `scen_abort` in any state leads to IDLE on the next edge, clears the counter and drops all pulses; it overrides any simultaneous transition.
- `scen_start` outside IDLE is ignored.
- `scen_start` together with `scen_abort` in IDLE: the abort wins and the FSM stays in IDLE.

## Timing
- All outputs are registered Moore decodes of state and counter; there is no combinational input-to-output path.
- Reset (asynchronous, `reset_n`=0): state IDLE, `counter_out`=0, `output_trigger`=0, `detonation_signal`=0, `scenario_state`=0, `busy`=0, `error`=0. This holds mid-pulse, and outputs fall without waiting for a clock edge.
- IDLE to WAIT_TRIG latency: 1 cycle after `scen_start` is sampled.
- Let E be the edge at which the FSM enters DELAY_TRIG:
  - `output_trigger` is high for edges E+D+1 … E+D+P, with D=`trig_delay` and P=max(`pulse_len`,1).
  - `detonation_signal` is high for edges E+D+P+K+2 … E+D+2P+K+1, with K=`det_delay`.
  - DONE follows at the next edge, and IDLE one edge later.
- Phase alignment adds the wait for the first `phase_ref` rising edge detected after the trigger edge; the trigger and phase edges are never taken in the same cycle.

## Test plan
- **Experiment sequence:** EXPERIMENT, trig_delay=3, det_delay=5, pulse_len=2, trigger edge at edge E → `output_trigger` high at E+4,E+5; `detonation_signal` high at E+12,E+13; DONE at E+14; IDLE at E+15; `counter_out` in DELAY_DET counts 0..5.
- **Calibration suppression:** CALIBRATION with the same parameters → `output_trigger` timing identical; `detonation_signal` stays 0 throughout; `scenario_state` still visits 6 for 2 cycles.
- **Phase alignment:** EXPERIMENT_PHASE, trigger edge, then `phase_ref` rising 7 cycles later → `scenario_state`=2 for those cycles; DELAY_TRIG entered on the phase-edge detection; a `phase_ref` edge arriving before the trigger is ignored.
- **Boundary parameters:** trig_delay=0, det_delay=0, pulse_len=0 → `output_trigger` high exactly 1 cycle at E+1, `detonation_signal` high at E+3; an `input_trigger` already high at arm → no start until it drops and rises again.
- **Abort and reset:** `scen_abort` during PULSE_TRIG → next edge IDLE with all outputs 0; async `reset_n` low mid-DELAY_DET → outputs 0 immediately; `scen_start` with `scen_abort` in the same cycle → stays IDLE.
- **Invalid scenario:** `scen_sel`=9 on start → ERROR (`scenario_state`=8, `error`=1, `busy`=1) with no pulses; ERROR is held against further `scen_start` pulses; `scen_abort` returns the FSM to IDLE.
